// File: rtl/sobel_grad.sv
// Streaming 3x3 Sobel gradient stage: two line buffers build the window, then
// a 2-stage pipeline produces a saturated |Gx|+|Gy| magnitude and a quantized direction.
module sobel_grad #(
  parameter int IMG_WIDTH = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_frame_start,
  input  logic       i_row_end,
  input  logic [7:0] i_pixel,
  output logic       o_valid,
  output logic       o_row_end,
  output logic [7:0] o_magnitude,
  output logic [1:0] o_direction
);
  localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [1:0]    row_q, row_d, cur_row;
  logic          row_last;

  // frame_start overrides the stored position for this very pixel
  assign cur_col  = i_frame_start ? '0 : col_q;
  assign cur_row  = i_frame_start ? '0 : row_q;
  assign row_last = i_row_end || (cur_col == CW'(IMG_WIDTH - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_valid) begin
      if (row_last) begin
        col_d = '0;
        row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers: A holds row r-1, B holds row r-2. No reset; interior gating hides stale data.
  logic [7:0] lb_a [IMG_WIDTH];
  logic [7:0] lb_b [IMG_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lb_b[cur_col] <= lb_a[cur_col];
      lb_a[cur_col] <= i_pixel;
    end
  end

  // win_q[column][row]: column 0 oldest (left), row 0 top, row 2 incoming
  logic [2:0][2:0][7:0] win_q;
  logic [2:0]           vld_pipe_q, re_pipe_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_q      <= '0;
      vld_pipe_q <= '0;
      re_pipe_q  <= '0;
    end else begin
      if (i_valid) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= {i_pixel, lb_a[cur_col], lb_b[cur_col]};
      end
      vld_pipe_q <= {vld_pipe_q[1:0], i_valid && (cur_row == 2'd2) && (cur_col >= CW'(2))};
      re_pipe_q  <= {re_pipe_q[1:0], i_valid && row_last};
    end
  end

  function automatic logic [10:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return {3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c};
  endfunction

  logic        [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx_q, gy_q;

  assign gx_pos = wsum(win_q[2][0], win_q[2][1], win_q[2][2]);
  assign gx_neg = wsum(win_q[0][0], win_q[0][1], win_q[0][2]);
  assign gy_pos = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
  assign gy_neg = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      gx_q <= signed'(gx_pos - gx_neg);
      gy_q <= signed'(gy_pos - gy_neg);
    end
  end

  logic [9:0]  ax, ay;
  logic [10:0] mag_sum;
  logic [12:0] ax2, ax5, ay2, ay5;
  logic [7:0]  mag_d;
  logic [1:0]  dir_d;

  assign ax      = gx_q[10] ? 10'(-gx_q) : gx_q[9:0];
  assign ay      = gy_q[10] ? 10'(-gy_q) : gy_q[9:0];
  assign mag_sum = {1'b0, ax} + {1'b0, ay};
  assign mag_d   = (mag_sum > 11'd255) ? 8'd255 : mag_sum[7:0];
  assign ax2     = {2'b0, ax, 1'b0};
  assign ay2     = {2'b0, ay, 1'b0};
  assign ax5     = {1'b0, ax, 2'b0} + {3'b0, ax};
  assign ay5     = {1'b0, ay, 2'b0} + {3'b0, ay};

  // tan(22.5) ~ 2/5 and tan(67.5) ~ 5/2 set the sector boundaries
  always_comb begin
    dir_d = 2'd3;
    if (ay5 <= ax2)
      dir_d = 2'd0;
    else if (ay2 >= ax5)
      dir_d = 2'd2;
    else if ((gx_q > 0 && gy_q > 0) || (gx_q < 0 && gy_q < 0))
      dir_d = 2'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_magnitude <= '0;
      o_direction <= '0;
    end else begin
      o_magnitude <= mag_d;
      o_direction <= dir_d;
    end
  end

  assign o_valid   = vld_pipe_q[2];
  assign o_row_end = vld_pipe_q[2] & re_pipe_q[2];

endmodule

// File: tb/tb_sobel_grad.sv
// Directed bench for sobel_grad: 8x8 frames of known patterns, checked per output
// for value, row-end tag and exact 2-cycle latency, plus reset and gap sequences.
module tb_sobel_grad;
  localparam int W = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_frame_start = 1'b0;
  logic       i_row_end = 1'b0;
  logic [7:0] i_pixel = '0;
  logic       o_valid, o_row_end;
  logic [7:0] o_magnitude;
  logic [1:0] o_direction;

  sobel_grad #(.IMG_WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_frame_start(i_frame_start), .i_row_end(i_row_end), .i_pixel(i_pixel),
    .o_valid(o_valid), .o_row_end(o_row_end),
    .o_magnitude(o_magnitude), .o_direction(o_direction)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] mag;
    logic [1:0] dir;
    logic       re;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int         kind;
    bit         gaps;
    bit         fs;
    logic [7:0] mag_edge;   // centre columns 3,4
    logic [7:0] mag_other;
    logic [1:0] dir;
  } vec_t;

  int nout = 0;
  int nre  = 0;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missing_output", 0, 1);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("valid", int'(o_valid), 1);
        chk("magnitude", int'(o_magnitude), int'(q[0].mag));
        chk("direction", int'(o_direction), int'(q[0].dir));
        chk("row_end", int'(o_row_end), int'(q[0].re));
        void'(q.pop_front());
      end else if (o_valid) begin
        chk("spurious_valid", 1, 0);
      end
      if (o_valid) nout++;
      if (o_valid && o_row_end) nre++;
    end
  end

  function automatic logic [7:0] pix(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return 8'(10 * c);
      2:       return 8'(10 * r);
      3:       return 8'(10 * (r + c));
      4:       return 8'(10 * (7 - r) + 10 * c);
      default: return (c >= 4) ? 8'd255 : 8'd0;
    endcase
  endfunction

  task automatic send_frame(input vec_t v, input int npix);
    for (int n = 0; n < npix; n++) begin
      int r, c;
      r = n / W;
      c = n % W;
      @(negedge i_clk);
      i_valid       = 1'b1;
      i_frame_start = v.fs && (n == 0);
      i_row_end     = (c == W - 1);
      i_pixel       = pix(v.kind, r, c);
      if (r >= 2 && c >= 2) begin
        exp_t e;
        e.cyc = cyc + 3;
        e.mag = (c - 1 == 3 || c - 1 == 4) ? v.mag_edge : v.mag_other;
        e.dir = v.dir;
        e.re  = (c == W - 1);
        q.push_back(e);
      end
      if (v.gaps) begin
        @(negedge i_clk);
        i_valid = 1'b0;
        i_pixel = 8'hxx;
      end
    end
    @(negedge i_clk);
    i_valid       = 1'b0;
    i_frame_start = 1'b0;
    i_row_end     = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge i_clk);
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{kind: 0, gaps: 0, fs: 1, mag_edge: 0,   mag_other: 0,   dir: 0};
    vecs[1] = '{kind: 1, gaps: 0, fs: 1, mag_edge: 80,  mag_other: 80,  dir: 0};
    vecs[2] = '{kind: 2, gaps: 0, fs: 1, mag_edge: 80,  mag_other: 80,  dir: 2};
    vecs[3] = '{kind: 3, gaps: 0, fs: 1, mag_edge: 160, mag_other: 160, dir: 1};
    vecs[4] = '{kind: 4, gaps: 0, fs: 1, mag_edge: 160, mag_other: 160, dir: 3};
    vecs[5] = '{kind: 5, gaps: 0, fs: 1, mag_edge: 255, mag_other: 0,   dir: 0};
    vecs[6] = '{kind: 3, gaps: 1, fs: 1, mag_edge: 160, mag_other: 160, dir: 1};
    vecs[7] = '{kind: 3, gaps: 1, fs: 1, mag_edge: 160, mag_other: 160, dir: 1};

    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_row_end", int'(o_row_end), 0);
    chk("rst_magnitude", int'(o_magnitude), 0);
    chk("rst_direction", int'(o_direction), 0);
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      nout = 0;
      nre  = 0;
      send_frame(vecs[i], W * W);
      drain();
      chk($sformatf("frame%0d_outputs", i), nout, 36);
      chk($sformatf("frame%0d_row_ends", i), nre, 6);
    end

    // Reset while an output is on the port and another is in flight
    send_frame(vecs[3], 3 * W + 4);
    @(posedge i_clk);
    #2;
    chk("pre_reset_valid", int'(o_valid), 1);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(o_valid), 0);
    chk("async_rst_magnitude", int'(o_magnitude), 0);
    chk("async_rst_direction", int'(o_direction), 0);
    q.delete();
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b1;

    // After reset the first pixel is (0,0) without frame_start
    nout = 0;
    nre  = 0;
    send_frame('{kind: 1, gaps: 0, fs: 0, mag_edge: 80, mag_other: 80, dir: 0}, W * W);
    drain();
    chk("post_reset_outputs", nout, 36);
    chk("post_reset_row_ends", nre, 6);

    // Partial row then a mid-row frame_start: position must restart at (0,0)
    nout = 0;
    send_frame('{kind: 0, gaps: 0, fs: 1, mag_edge: 0, mag_other: 0, dir: 0}, 3);
    send_frame('{kind: 2, gaps: 0, fs: 1, mag_edge: 80, mag_other: 80, dir: 2}, W * W);
    drain();
    chk("restart_outputs", nout, 36 + 0);

    repeat (4) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_grad.md
# sobel_grad

Streaming Sobel gradient stage placed directly downstream of `blur` in the edge-detection pipeline. It consumes blur's 8-bit pixel stream (valid / row-end framing), keeps two line buffers to build a 3×3 window, and emits a saturated gradient magnitude plus a 2-bit quantized direction for every interior pixel. Its output feeds the non-maximum-suppression stage.

## Interface
- `IMG_WIDTH`, default 64: maximum pixels per row and depth of each line buffer.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  `i_pixel` is accepted on this edge.
- `i_frame_start`  in  1  qualified by `i_valid`; this pixel is row 0, column 0.
- `i_row_end`  in  1  qualified by `i_valid`; this pixel is the last of its row.
- `i_pixel`  in  8  blurred grey pixel, unsigned.
- `o_valid`  out  1  gradient outputs valid this cycle.
- `o_row_end`  out  1  with `o_valid`; last interior output of a row.
- `o_magnitude`  out  8  min(|Gx|+|Gy|, 255).
- `o_direction`  out  2  0 = 0°, 1 = 45°, 2 = 90°, 3 = 135°.

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (saturates at 2) track the accepted pixel position. The same-cycle `i_frame_start` forces the position to (0,0).
- After each accepted pixel:
  - if `i_row_end`, or if `col == IMG_WIDTH-1` (implicit row end), then `col` becomes 0 and `row` increments (saturating);
  - otherwise `col` increments.
- Line buffers A (row r-1) and B (row r-2), each IMG_WIDTH × 8 bits. On an accepted pixel at column c:
  - read column {B[c], A[c], pixel} into the 3-column window shift register;
  - then write B[c] ← A[c] and A[c] ← pixel.
- Window layout: top row p1 p2 p3, middle row p4 p5 p6, bottom row p7 p8 p9. Left column is oldest; bottom row is the incoming row.
- Gx = (p3 + 2·p6 + p9) − (p1 + 2·p4 + p7). Gy = (p7 + 2·p8 + p9) − (p1 + 2·p2 + p3). Both are 11-bit signed, range ±1020.
- Magnitude: ax = |Gx|, ay = |Gy|, sum held in 11 bits. Output 255 if sum > 255, else sum[7:0].
- Direction, evaluated in priority order:
  - 0 if 5·ay ≤ 2·ax (this includes Gx = Gy = 0);
  - else 2 if 2·ay ≥ 5·ax;
  - else 1 if Gx and Gy are both strictly positive or both strictly negative;
  - else 3.
- Interior gating: an output is produced only when the accepted pixel has row ≥ 2 and col ≥ 2. That output is the gradient centred at (row-1, col-1). A W×H frame yields (W-2)×(H-2) outputs.
- `o_row_end` is set when the producing pixel carried `i_row_end` or an implicit row end.
- Line buffers are not reset. Their stale contents are never exposed because of interior gating.
- Rows shorter than IMG_WIDTH are legal. All rows of a frame have the same width.

## Timing
- Reset: `o_valid`, `o_row_end`, `o_magnitude`, `o_direction` = 0. Counters = 0. Window and pipeline valid bits cleared.
- Pipeline:
  - stage 0 (input edge): window capture, valid/row-end tags;
  - stage 1: Gx, Gy registered;
  - stage 2: magnitude, direction and outputs registered.
- Latency: outputs appear exactly 2 cycles after the edge that accepted the completing pixel.
- The pipeline advances every cycle regardless of `i_valid`. Gaps in the input produce equal gaps in `o_valid`. There is no backpressure.
- Accepting a pixel every cycle gives one output per cycle for interior pixels.
- `i_frame_start` arriving mid-row: the position resets immediately. Outputs already in flight still emit.
- Asynchronous reset mid-frame: in-flight outputs are dropped, and the next accepted pixel is treated as (0,0).
- `i_row_end` and `i_frame_start` on the same pixel: the pixel is (0,0) of a new frame and also a row end. Next pixel is (1,0).

## Test plan
- Reset: hold `i_rst_n` low mid-stream. All outputs read 0 immediately (asynchronously), and `o_valid` stays 0 until 2 cycles after the first interior pixel.
- IMG_WIDTH = 8, 8×8 frame of constant 100, `i_valid` every cycle → 36 outputs, each with magnitude 0 and direction 0. `o_row_end` fires 6 times, on every 6th output.
- Horizontal ramp, pixel = 10·col → every output has magnitude 80, direction 0. Vertical ramp, pixel = 10·row → magnitude 80, direction 2.
- Diagonal, pixel = 10·(row+col) → magnitude 160, direction 1. Anti-diagonal, pixel = 10·(7−row) + 10·col → magnitude 160, direction 3.
- Step edge, columns 0–3 = 0 and columns 4–7 = 255 → centre columns 3 and 4 give magnitude 255 (saturated), direction 0. All other centres give 0.
- Diagonal frame with `i_valid` low every other cycle, then a second frame started by `i_frame_start` → identical value sequence to the gap-free run. Each `o_valid` occurs exactly 2 cycles after its completing pixel, and the second frame's first output arrives after its own row 2, column 2.
